// File: rtl/rom2_pkg.sv
// Shared definitions for the two-port ROM read arbiter.
// ROM_OUTREG_EN: the ROM output register is enabled, adding one cycle of read latency.
package rom2_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Edges from the ROM sampling its address until this block may capture rom_q.
  function automatic int rom_lat_eff(input int rom_lat);
`ifdef ROM_OUTREG_EN
    return rom_lat + 1;
`else
    return rom_lat;
`endif
  endfunction

endpackage

// File: rtl/rom2_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that was not granted last time wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic gnt_o,
  output logic any_req_o
);

  assign any_req_o = req0_i | req1_i;
  assign gnt_o     = (req0_i & req1_i) ? ~last_gnt_i : req1_i;

endmodule

// File: rtl/rom2_rd_arbiter.sv
// Shares one synchronous ROM between two read ports with round-robin arbitration.
// Build with ROM_OUTREG_EN when the ROM output register is enabled (one extra cycle).
module rom2_rd_arbiter
  import rom2_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              inclk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  localparam int LAT_EFF = rom_lat_eff(ROM_LAT);
  localparam int CNT_W   = $clog2(LAT_EFF + 1);

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [1:0]               ack_q, ack_d;
  logic [1:0]               rv_q, rv_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;

  logic gnt, any_req;

  rr_arb2 u_arb (
    .req0_i     (req0),
    .req1_i     (req1),
    .last_gnt_i (last_q),
    .gnt_o      (gnt),
    .any_req_o  (any_req)
  );

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = '0;
    rv_d    = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d       = gnt ? addr1 : addr0;
          ack_d[gnt]   = 1'b1;
          owner_d      = gnt;
          last_d       = gnt;
          cnt_d        = CNT_W'(LAT_EFF);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // The count covers the ROM latency; capture happens on the edge after it hits zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d[owner_q] = rom_q;
          rv_d[owner_q]    = 1'b1;
          state_d          = IDLE;
        end
      end
    endcase
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign rvalid0  = rv_q[0];
  assign rvalid1  = rv_q[1];
  assign rdata0   = rdata_q[0];
  assign rdata1   = rdata_q[1];
  assign rom_addr = addr_q;
  assign busy     = (state_q == WAIT);

endmodule

// File: doc/rom2_rd_arbiter.md
Name: rom2_rd_arbiter

Overview:
- Shares one synchronous 16x4 ROM (registered address, q valid one inclk edge after address sampling) between two independent read requesters.
- Arbitrates round-robin between them.
- Sequences each read through the ROM latency.
- Returns data with a one-cycle valid pulse per requester.
- Sits between client logic and the ROM instance; owns the ROM address bus exclusively.

Parameters:
ADDR_W, 4, ROM address width (16 words)
DATA_W, 4, ROM data width
ROM_LAT, 1, inclk edges from ROM sampling rom_addr to rom_q valid (>=1)

Ports:
inclk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 read request, held until ack0
addr0  in  ADDR_W  port 0 read address, stable while req0=1
ack0  out  1  one-cycle pulse: port 0 request accepted
rvalid0  out  1  one-cycle pulse: rdata0 valid
rdata0  out  DATA_W  port 0 read data, held until next port 0 response
req1/addr1/ack1/rvalid1/rdata1  same as port 0, for port 1
rom_addr  out  ADDR_W  address to ROM
rom_q  in  DATA_W  ROM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock inclk; reset asynchronous, active-low (rst_n).
- Reset values: ack0/1=0, rvalid0/1=0, rdata0/1=0, rom_addr=0, busy=0, state=IDLE, owner=0, last_gnt=1 (port 0 wins first tie), cnt=0.
- States: IDLE, WAIT. All outputs registered.
- IDLE, edge E0 with any req high:
  - Winner chosen; rom_addr<=addr_winner; ack_winner<=1; owner<=winner; last_gnt<=winner; cnt<=ROM_LAT_EFF; state<=WAIT.
  - No req high: stay IDLE, outputs unchanged except pulses clear.
- Arbitration:
  - Single requester always wins.
  - Both requesting: grant the port != last_gnt.
- WAIT, each edge:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: rdata_owner<=rom_q; rvalid_owner<=1; state<=IDLE.
- Timing with ROM_LAT=1:
  - ROM samples at E1; capture at E2; rvalid high during cycle after E2.
  - Next grant possible at E3. Throughput one read per ROM_LAT_EFF+2 cycles.
- ack and rvalid are exactly one cycle wide; the non-owner's rvalid/rdata never change.
- Requester must drop req on seeing ack for a single read. If req is still high at the next IDLE edge, a new read is issued, which is legal back-to-back use.
- req dropped before being granted: no ack, no read.
- rom_addr holds its last value in IDLE; no ROM enable is required.
- Reset mid-read: everything clears immediately; in-flight read is discarded, with no rvalid and no ack after reset release.
- ROM_LAT_EFF = ROM_LAT, or ROM_LAT+1 with the option below.

Optional Feature:
- Macro ROM_OUTREG_EN.
- Defined: the ROM instance has its output register enabled (extra outclk-style stage), so ROM_LAT_EFF=ROM_LAT+1. Capture is one edge later and the read period is one cycle longer.
- Undefined: ROM_LAT_EFF=ROM_LAT.

Decomposition:
- Shared package/header rom2_pkg: ADDR_W/DATA_W defaults, state encodings IDLE/WAIT, ROM_LAT_EFF derivation under ROM_OUTREG_EN.
- One sub-module rr_arb2: combinational 2-way round-robin pick from req0, req1, last_gnt. Returns grant index and any_req.
- FSM, counter and data capture stay in top.

Test Plan:
- Bench ROM model: mem[a]=a^4'hA, ROM_LAT=1.
- Single read: req0=1, addr0=3 at E0 -> ack0 pulse cycle after E0; rvalid0 pulse after E2 with rdata0=4'h9. Port 1 outputs stay 0.
- Contention: req0=req1=1 from reset, addr0=2, addr1=5 -> port 0 served first (rdata0=8); port 1 acked at E3, rdata1=4'hF. Then alternates 0,1,0,1 while both are held.
- Back-to-back: req1 held high with addr1 stepping 0..15 on each ack1 -> 16 rvalid1 pulses, 3 cycles apart, rdata1 = addr^4'hA each time.
- Reset mid-read: assert rst_n=0 between E1 and E2 of a port 0 read -> all outputs 0 immediately; no rvalid0 after release; next req0 (addr 7) returns 4'hD.
- ROM_OUTREG_EN defined with a 2-stage ROM model: single read of addr 0 -> rvalid0 after E3, rdata0=4'hA; period 4 cycles.
- Dropped request: req1 pulsed for one cycle while port 0 owns the ROM -> no ack1 and no rvalid1 ever; busy falls after the port 0 response.
